fadd: RTL and testbench

FADD -- requirements
Module: fadd

---
 rtl/fadd_pkg.sv | 14 +
 rtl/fadd_lzc.sv | 17 +
 rtl/fadd.sv | 145 ++++++++++++++
 tb/tb_fadd.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// Shared types and constants for the single-precision adder.
package fadd_pkg;

    localparam logic [7:0]  EXP_MAX      = 8'hFF;
    localparam int          MANT_W       = 23;
    localparam logic [31:0] QNAN_DEFAULT = 32'hFFC0_0000;

    typedef struct packed {
        logic                sign;
        logic [7:0]          exp;
        logic [MANT_W-1:0]   mant;
    } fp32_t;

endpackage

// File: rtl/fadd_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fadd_lzc (
    input  logic [26:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd27;
        // Ascending scan: the last hit is the most significant set bit.
        for (int i = 0; i < 27; i++) begin
            if (din[i]) begin
                cnt = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fadd.sv
// IEEE-754 binary32 adder, round-to-nearest-even, full subnormal support.
// Combinational datapath and special-case mux feed a single output register.
module fadd
    import fadd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    // Significand layout: {hidden, mant[22:0], guard, round, sticky}.
    function automatic logic [33:0] round_rne(input logic [26:0] m, input logic [9:0] e);
        logic        up;
        logic [24:0] r;
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {1'b0, m[26:3]} + {24'b0, up};
        if (r[24]) begin
            return {e + 10'd1, r[24:1]};
        end
        return {e, r[23:0]};
    endfunction

    fp32_t       a, b, big, sml;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        swap, eff_sub;
    logic [7:0]  e_big, e_sml, d_exp, lsh_lim;
    logic [23:0] m_big, m_sml;
    logic [49:0] sh_ext;
    logic [26:0] al, diff, norm;
    logic [27:0] sum;
    logic [4:0]  lz, lsh;
    logic [9:0]  exp_n, r_exp;
    logic [33:0] rnd;
    logic [23:0] r_mant;
    logic        r_sign;
    logic [31:0] main_y, y_d, y_q;
    logic        main_ovf, ovf_d, ovf_q;

    assign a = fp32_t'(x1);
    assign b = fp32_t'(x2);

    assign a_nan  = (a.exp == EXP_MAX) && (a.mant != '0);
    assign b_nan  = (b.exp == EXP_MAX) && (b.mant != '0);
    assign a_inf  = (a.exp == EXP_MAX) && (a.mant == '0);
    assign b_inf  = (b.exp == EXP_MAX) && (b.mant == '0);
    assign a_zero = (a.exp == 8'd0) && (a.mant == '0);
    assign b_zero = (b.exp == 8'd0) && (b.mant == '0);

    // Order by magnitude so the subtraction below never goes negative.
    assign swap = {b.exp, b.mant} > {a.exp, a.mant};
    assign big  = swap ? b : a;
    assign sml  = swap ? a : b;

    assign e_big = (big.exp == 8'd0) ? 8'd1 : big.exp;
    assign e_sml = (sml.exp == 8'd0) ? 8'd1 : sml.exp;
    assign m_big = {big.exp != 8'd0, big.mant};
    assign m_sml = {sml.exp != 8'd0, sml.mant};
    assign d_exp = e_big - e_sml;

    // Alignment keeps 26 bits in-window; everything below folds into sticky.
    assign sh_ext = {m_sml, 26'b0} >> d_exp;
    assign al     = (d_exp >= 8'd26) ? {26'b0, |m_sml} : {sh_ext[49:24], |sh_ext[23:0]};

    assign eff_sub = a.sign ^ b.sign;
    assign sum     = eff_sub ? ({1'b0, m_big, 3'b0} - {1'b0, al})
                             : ({1'b0, m_big, 3'b0} + {1'b0, al});
    assign diff    = sum[26:0];

    fadd_lzc u_lzc (
        .din (diff),
        .cnt (lz)
    );

    // Stop normalising at exponent 1 so the result lands in the subnormal range.
    assign lsh_lim = e_big - 8'd1;
    assign lsh     = ({3'b0, lz} < lsh_lim) ? lz : lsh_lim[4:0];

    always_comb begin
        norm  = diff;
        exp_n = {2'b0, e_big};
        if (eff_sub) begin
            norm  = diff << lsh;
            exp_n = {2'b0, e_big} - {5'b0, lsh};
        end else if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b0, e_big} + 10'd1;
        end
    end

    assign rnd    = round_rne(norm, exp_n);
    assign r_exp  = rnd[33:24];
    assign r_mant = rnd[23:0];
    assign r_sign = (eff_sub && (diff == '0)) ? 1'b0 : big.sign;

    always_comb begin
        main_y   = {r_sign, (r_mant[23] ? r_exp[7:0] : 8'd0), r_mant[22:0]};
        main_ovf = 1'b0;
        if (r_exp >= 10'd255) begin
            main_y   = {r_sign, EXP_MAX, 23'b0};
            main_ovf = 1'b1;
        end
    end

    // Special operands override the arithmetic result.
    always_comb begin
        y_d   = main_y;
        ovf_d = main_ovf;
        if (a_nan) begin
            y_d   = x1 | 32'h0040_0000;
            ovf_d = 1'b0;
        end else if (b_nan) begin
            y_d   = x2 | 32'h0040_0000;
            ovf_d = 1'b0;
        end else if (a_inf && b_inf) begin
            y_d   = (a.sign == b.sign) ? x1 : QNAN_DEFAULT;
            ovf_d = 1'b0;
        end else if (a_inf) begin
            y_d   = x1;
            ovf_d = 1'b0;
        end else if (b_inf) begin
            y_d   = x2;
            ovf_d = 1'b0;
        end else if (a_zero && b_zero) begin
            y_d   = {a.sign & b.sign, 31'b0};
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign y   = y_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_fadd.sv
// Bench for fadd: directed vectors plus a randomized sweep checked against an
// exact-integer reference (values summed in units of 2^-149, then RNE-rounded).
module tb_fadd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, x2, y;
    logic        ovf;
    int          checks = 0;
    int          errors = 0;

    fadd dut (
        .clk (clk),
        .rst (rst),
        .x1  (x1),
        .x2  (x2),
        .y   (y),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, y}.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, q, rem, half;
        logic         sa, sb, sr;
        logic [7:0]   fa, fb;
        logic [22:0]  ta, tb;
        int           p, sh;
        sa = a[31]; fa = a[30:23]; ta = a[22:0];
        sb = b[31]; fb = b[30:23]; tb = b[22:0];
        if (fa == 8'hFF && ta != 0) return {1'b0, a | 32'h0040_0000};
        if (fb == 8'hFF && tb != 0) return {1'b0, b | 32'h0040_0000};
        if (fa == 8'hFF && fb == 8'hFF) return (sa == sb) ? {1'b0, a} : {1'b0, 32'hFFC0_0000};
        if (fa == 8'hFF) return {1'b0, a};
        if (fb == 8'hFF) return {1'b0, b};
        ma = {276'b0, fa != 8'd0, ta} << ((fa == 8'd0) ? 0 : int'(fa) - 1);
        mb = {276'b0, fb != 8'd0, tb} << ((fb == 8'd0) ? 0 : int'(fb) - 1);
        if (sa == sb) begin
            mag = ma + mb; sr = sa;
        end else if (ma > mb) begin
            mag = ma - mb; sr = sa;
        end else if (mb > ma) begin
            mag = mb - ma; sr = sb;
        end else begin
            mag = '0; sr = 1'b0;
        end
        if (mag == 0) return {1'b0, sr, 31'b0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {1'b0, sr, mag[30:0]};
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag & ((300'b1 << sh) - 300'b1);
        half = 300'b1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 300'b1;
        if (q[24]) begin
            q = q >> 1;
            sh++;
        end
        if (sh + 1 >= 255) return {1'b1, sr, 8'hFF, 23'b0};
        return {1'b0, sr, 8'(sh + 1), q[22:0]};
    endfunction

    function automatic logic [22:0] pick_mant();
        case ($urandom_range(0, 7))
            0: return 23'h000000;
            1: return 23'h000001;
            2: return 23'h000002;
            3: return 23'h380000;
            4: return 23'h400000;
            5: return 23'h5FFFFF;
            6: return 23'h7FFFFF;
            default: return 23'($urandom);
        endcase
    endfunction

    task automatic apply_exp(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ey, input logic eovf, input string tag);
        @(negedge clk);
        x1 = a;
        x2 = b;
        @(posedge clk);
        #1;
        checks++;
        assert (y === ey) else begin
            errors++;
            $error("FAIL %s y: x1=%h x2=%h got %h want %h", tag, a, b, y, ey);
        end
        checks++;
        assert (ovf === eovf) else begin
            errors++;
            $error("FAIL %s ovf: x1=%h x2=%h got %b want %b", tag, a, b, ovf, eovf);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [32:0] r;
        r = ref_add(a, b);
        apply_exp(a, b, r[31:0], r[32], tag);
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (y === 32'h0) else begin
            errors++;
            $error("FAIL %s y: got %h want 00000000", tag, y);
        end
        checks++;
        assert (ovf === 1'b0) else begin
            errors++;
            $error("FAIL %s ovf: got %b want 0", tag, ovf);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [7:0]  e;
        logic [22:0] m;
        logic        s;

        rst = 1'b1;
        x1  = 32'h7F7F_FFFF;
        x2  = 32'h7F7F_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_init");
        @(negedge clk);
        rst = 1'b0;

        apply_exp(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, "one_plus_one");
        apply_exp(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, "tie_even");
        apply_exp(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 1'b0, "tie_odd");
        apply_exp(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, "cancel");
        apply_exp(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, "sub_add");
        apply_exp(32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, 1'b0, "to_subnormal");
        apply_exp(32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000, 1'b0, "sub_carry");
        apply_exp(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, "inf_fin");
        apply_exp(32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000, 1'b0, "inf_minus_inf");
        apply_exp(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b0, "ninf_ninf");
        apply_exp(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0001, 1'b0, "nan_x1");
        apply_exp(32'h3F80_0000, 32'hFF80_0001, 32'hFFC0_0001, 1'b0, "nan_x2");
        apply_exp(32'h7F80_0001, 32'hFFC0_0002, 32'h7FC0_0001, 1'b0, "nan_both");
        apply_exp(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, "nzero_nzero");
        apply_exp(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "pzero_nzero");
        apply_exp(32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000, 1'b1, "neg_overflow");
        apply_exp(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, "overflow");

        // Reset mid-stream, right after an overflow so ovf has to drop.
        @(negedge clk);
        rst = 1'b1;
        x1  = 32'h3F80_0000;
        x2  = 32'h3F80_0000;
        @(posedge clk);
        #1;
        check_reset("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        apply_exp(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0, "after_reset");

        for (int e1 = 0; e1 < 256; e1++) begin
            for (int e2 = (e1 % 3); e2 < 256; e2 += 3) begin
                a = {1'($urandom), 8'(e1), pick_mant()};
                b = {1'($urandom), 8'(e2), pick_mant()};
                apply(a, b, "sweep");
            end
        end

        for (int k = 0; k < 2000; k++) begin
            e = 8'($urandom_range(0, 254));
            m = pick_mant();
            s = 1'($urandom);
            a = {s, e, m};
            b = {~s, e, m ^ 23'($urandom_range(0, 15))};
            apply(a, b, "near_cancel");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
